dram_rr_arbiter: RTL
====================

Name: dram_rr_arbiter

Overview:
Three-port round-robin arbiter that shares the single DRAM controller port between instruction fetch (port 0, read), CPU data (port 1, read/write) and DMA/video (port 2, read).
- Latches the winning requester's address and data, then holds the DRAM request level until the controller responds.
- Returns a one-cycle completion pulse to the owning port.
- A timeout watchdog aborts stalled accesses so the CPU cannot hang on a lost DRAM response.

Parameters:
ADDR_WIDTH, 24, DRAM word address width
DATA_WIDTH, 32, DRAM data width
TMO_WIDTH, 8, width of the timeout counter
TIMEOUT, 255, cycles in ISSUE before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
addr0  in  ADDR_WIDTH  port 0 read address
req_read0  in  1  port 0 read request, level
addr1  in  ADDR_WIDTH  port 1 address
data_in1  in  DATA_WIDTH  port 1 write data
req_read1  in  1  port 1 read request, level
req_write1  in  1  port 1 write request, level
addr2  in  ADDR_WIDTH  port 2 read address
req_read2  in  1  port 2 read request, level
rd_data  out  DATA_WIDTH  last read data, shared by all ports
data_valid0/1/2  out  1 each  read complete pulse for port n
write_complete1  out  1  write complete pulse, port 1
error0/1/2  out  1 each  timeout abort pulse for port n
grant  out  3  one-hot current owner, 0 when idle
dram_addr  out  ADDR_WIDTH  to DRAM controller
dram_data_in  out  DATA_WIDTH  write data to DRAM
dram_req_read  out  1  DRAM read request, level
dram_req_write  out  1  DRAM write request, level
dram_data_out  in  DATA_WIDTH  DRAM read data
dram_data_out_valid  in  1  DRAM read data valid pulse
dram_write_complete  in  1  DRAM write done pulse

Behaviour:
- All outputs are registered. Reset state:
  - State IDLE.
  - All pulses, grant and dram_req_* are 0.
  - rd_data, dram_addr and dram_data_in are 0.
  - Timeout counter is 0.
  - RR pointer last = 2, so port 0 has first priority.
- States: IDLE, ISSUE, DONE.
- IDLE: on each edge, scan ports in order last+1, last+2, last+3 (mod 3) and pick the first with a request.
  - On a win: latch the port's addr, and data_in1 for port 1, into dram_addr/dram_data_in.
  - Assert dram_req_read or dram_req_write, set grant, set last = winner, clear the counter, go to ISSUE.
  - No request: stay in IDLE.
- Port 1 with req_read1 and req_write1 both high is serviced as a write; the read is ignored.
- ISSUE: hold dram_req_*, dram_addr and dram_data_in stable; the counter increments each cycle.
  - Read grant and dram_data_out_valid=1: capture dram_data_out into rd_data, drop dram_req_read, pulse data_valid of the owner, go to DONE.
  - Write grant and dram_write_complete=1: drop dram_req_write, pulse write_complete1, go to DONE.
  - Response pulses that do not match the granted operation are ignored.
  - TIMEOUT!=0 and counter==TIMEOUT with no response: drop dram_req_*, pulse error of the owner, go to DONE. rd_data is unchanged.
- DONE: exactly one cycle.
  - The response/error pulse is high during this cycle; grant is still set.
  - Next edge: clear pulses and grant, go to IDLE.
  - A DRAM response arriving in DONE or IDLE is discarded.
- Requester rule: drop req on the edge at which it samples its completion pulse high. A req still high in IDLE is a new request.
- Latency:
  - req sampled at edge E0 gives dram_req visible after E0.
  - A DRAM response sampled at Ek gives the pulse in cycle Ek..Ek+1.
  - Minimum 2 cycles from grant to pulse.
  - Back-to-back issue every 3 cycles with a 1-cycle DRAM.
- Requester input changes after grant do not affect the in-flight access.
- rd_data holds its value until the next successful read.
- Synchronous rst mid-ISSUE or mid-DONE: next edge returns to the reset state; dram_req_* are deasserted that edge. A late DRAM response is discarded.

Test Plan:
- Port 0 read addr0=0xfe00; DRAM asserts valid with 0xdeadbeef 7 cycles after dram_req_read. Required: dram_addr=0xfe00, data_valid0 high for 1 cycle, rd_data=0xdeadbeef, grant=001 during access, then 000.
- Port 1 write addr1=0x3454, data_in1=0xfeed; write_complete after 4 cycles. Required: dram_req_write high, dram_data_in=0xfeed, write_complete1 pulse, no data_valid pulses.
- All three ports request simultaneously from reset, each dropping req on its pulse. Required: grant order 001, 010, 100; exactly one pulse per port.
- Ports 0 and 2 re-request continuously, DRAM latency 1. Required: grants alternate 0,2,0,2; a new dram_req_read every 3 cycles.
- TIMEOUT=15, port 2 read, DRAM never responds. Required: dram_req_read deasserted and error2 pulses 16 cycles after grant; rd_data unchanged; a later port 0 read succeeds.
- rst asserted 3 cycles into a port 1 read, DRAM valid arrives 2 cycles later. Required: dram_req_read=0 after the rst edge, no data_valid1, next arbitration starts with port 0 priority.

Source files
------------

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter
// Three-port round-robin arbiter that shares one DRAM controller port.
//   port 0 : instruction fetch, read only  (addr0, req_read0)
//   port 1 : CPU data, read/write           (addr1, data_in1, req_read1, req_write1)
//   port 2 : DMA/video, read only           (addr2, req_read2)
// The winner's address/data are latched and the DRAM request level is held
// until the controller answers or the watchdog expires. The owner then sees a
// one-cycle completion (data_validN / write_complete1) or abort (errorN) pulse.
// Outputs:
//   rd_data                        last successfully read word (all ports)
//   data_valid0/1/2                read completion pulses
//   write_complete1                write completion pulse
//   error0/1/2                     watchdog abort pulses
//   grant                          one-hot owner, 0 when idle
//   dram_addr/dram_data_in         latched access to the controller
//   dram_req_read/dram_req_write   request levels to the controller
// Inputs from the controller: dram_data_out, dram_data_out_valid,
// dram_write_complete. All outputs are registered; rst is synchronous.
module dram_rr_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req_read0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  req_read1,
  input  logic                  req_write1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic                  req_read2,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  data_valid0,
  output logic                  data_valid1,
  output logic                  data_valid2,
  output logic                  write_complete1,
  output logic                  error0,
  output logic                  error1,
  output logic                  error2,
  output logic [2:0]            grant,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_data_in,
  output logic                  dram_req_read,
  output logic                  dram_req_write,
  input  logic [DATA_WIDTH-1:0] dram_data_out,
  input  logic                  dram_data_out_valid,
  input  logic                  dram_write_complete
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [1:0] NO_WIN = 2'd3;

  state_t                state, state_nxt;
  logic [1:0]            last, last_nxt;
  logic [TMO_WIDTH-1:0]  cnt, cnt_nxt;
  logic [2:0]            grant_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt;
  logic [DATA_WIDTH-1:0] rd_nxt;
  logic                  rreq_nxt, wreq_nxt;
  logic [2:0]            dv_q, dv_nxt;
  logic [2:0]            err_q, err_nxt;
  logic                  wc_q, wc_nxt;
  logic [2:0]            req_vec;
  logic [1:0]            win;

  // Scan last+1, last+2, last+3 (mod 3); returns NO_WIN when nobody asks.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
    logic [1:0] cand;
    logic [1:0] pick;
    pick = NO_WIN;
    cand = ptr;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (pick == NO_WIN && req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign req_vec = {req_read2, req_read1 | req_write1, req_read0};
  assign win     = rr_pick(last, req_vec);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    addr_nxt  = dram_addr;
    din_nxt   = dram_data_in;
    rd_nxt    = rd_data;
    rreq_nxt  = dram_req_read;
    wreq_nxt  = dram_req_write;
    dv_nxt    = 3'b000;
    err_nxt   = 3'b000;
    wc_nxt    = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = 3'b000;
        rreq_nxt  = 1'b0;
        wreq_nxt  = 1'b0;
        if (win != NO_WIN) begin
          grant_nxt = 3'b001 << win;
          last_nxt  = win;
          cnt_nxt   = '0;
          state_nxt = ISSUE;
          case (win)
            2'd0:    addr_nxt = addr0;
            2'd1:    addr_nxt = addr1;
            default: addr_nxt = addr2;
          endcase
          if (win == 2'd1) din_nxt = data_in1;
          // A simultaneous read+write on port 1 is serviced as the write.
          wreq_nxt = (win == 2'd1) && req_write1;
          rreq_nxt = !((win == 2'd1) && req_write1);
        end
      end
      ISSUE: begin
        cnt_nxt = cnt + TMO_WIDTH'(1);
        // Response takes precedence over a watchdog expiry in the same cycle;
        // mismatched response pulses fall through and are ignored.
        if (dram_req_read && dram_data_out_valid) begin
          rd_nxt    = dram_data_out;
          rreq_nxt  = 1'b0;
          dv_nxt    = grant;
          state_nxt = DONE;
        end else if (dram_req_write && dram_write_complete) begin
          wreq_nxt  = 1'b0;
          wc_nxt    = 1'b1;
          state_nxt = DONE;
        end else if ((TIMEOUT != 0) && (cnt == TMO_WIDTH'(TIMEOUT))) begin
          rreq_nxt  = 1'b0;
          wreq_nxt  = 1'b0;
          err_nxt   = grant;
          state_nxt = DONE;
        end
      end
      DONE: begin
        grant_nxt = 3'b000;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = 3'b000;
        rreq_nxt  = 1'b0;
        wreq_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 2'd2;
      cnt            <= '0;
      grant          <= 3'b000;
      dram_addr      <= '0;
      dram_data_in   <= '0;
      rd_data        <= '0;
      dram_req_read  <= 1'b0;
      dram_req_write <= 1'b0;
      dv_q           <= 3'b000;
      err_q          <= 3'b000;
      wc_q           <= 1'b0;
    end else begin
      state          <= state_nxt;
      last           <= last_nxt;
      cnt            <= cnt_nxt;
      grant          <= grant_nxt;
      dram_addr      <= addr_nxt;
      dram_data_in   <= din_nxt;
      rd_data        <= rd_nxt;
      dram_req_read  <= rreq_nxt;
      dram_req_write <= wreq_nxt;
      dv_q           <= dv_nxt;
      err_q          <= err_nxt;
      wc_q           <= wc_nxt;
    end
  end

  assign data_valid0     = dv_q[0];
  assign data_valid1     = dv_q[1];
  assign data_valid2     = dv_q[2];
  assign error0          = err_q[0];
  assign error1          = err_q[1];
  assign error2          = err_q[2];
  assign write_complete1 = wc_q;

endmodule
